// File: rtl/output_buffer_drain.sv
// output_buffer_drain
//   Purpose : streams a completed N*N output feature map out of the on-chip
//             output buffer over a valid/ready interface.
//   Latency : start in cycle 0 -> first buf_rd_en in cycle 1 -> first m_valid
//             in cycle 3. With m_ready held high it streams 1 beat per cycle.
//   Backpressure: reads are throttled so that reads in flight plus FIFO
//             entries never exceed the 2-entry skid FIFO. Data is never lost.
//
// Ports:
//   w_clk, reset        clock and synchronous active-high reset
//   start, base_addr,
//   featuremap_size     drain request; base and side length N sampled on accept
//   buf_is_empty        start is ignored while the buffer holds no valid map
//   buf_rd_*            buffer read port (data returns one cycle after en)
//   buf_wr_*            clear-on-read write port (tied to 0 unless enabled)
//   m_valid/m_ready/
//   m_data/m_last       output stream; m_last marks the final beat
//   busy, done          status: busy while draining, done pulses for 1 cycle
//
// Build option: define DRAIN_CLEAR_ON_READ_EN to zero each buffer location one
// cycle after it is read, ready for the next accumulation pass.

module output_buffer_drain #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              w_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        featuremap_size,
  input  logic              buf_is_empty,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;             // next address to read
  logic [15:0]       r_rd_remaining;     // reads still to issue
  logic [15:0]       r_beats_remaining;  // beats still to hand downstream
  logic              r_inflight;         // a read was issued last cycle

  // 2-entry skid FIFO
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [15:0]       w_total;
  logic              w_start_ok;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occupancy;

  // 8x8 -> 16-bit product; 255*255 = 65025 still fits.
  assign w_total    = {8'd0, featuremap_size} * {8'd0, featuremap_size};
  assign w_start_ok = start & ~buf_is_empty & (r_state == S_IDLE);
  assign w_pop      = (r_count != 2'd0) & m_ready;

  // Slots committed after this edge if no new read is issued. A new read is
  // only allowed when it still leaves room for its data in the FIFO, which is
  // what lets m_ready feed straight into buf_rd_en without losing data.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_DRAIN) && (r_rd_remaining != 16'd0) &&
                       (w_occupancy < 3'd2);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (w_total == 16'd0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last beat always trails the last read by at least two cycles,
        // so the first branch is only a guard.
        if (w_pop && (r_beats_remaining == 16'd1)) begin
          w_state_nxt = S_DONE;
        end else if (w_issue && (r_rd_remaining == 16'd1)) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_pop && (r_beats_remaining == 16'd1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_rd_en   = w_issue;
    buf_rd_addr = r_addr;
    busy        = (r_state == S_DRAIN) || (r_state == S_FLUSH);
    done        = (r_state == S_DONE);
    m_valid     = (r_count != 2'd0);
    // Data is masked when not valid so the stream reads as 0 when idle.
    m_data      = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : '0;
    m_last      = (r_count != 2'd0) && (r_beats_remaining == 16'd1);
  end

  // ---------------------------------------------------------------------------
  // Counters, address and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_addr            <= '0;
      r_rd_remaining    <= 16'd0;
      r_beats_remaining <= 16'd0;
      r_inflight        <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_addr            <= base_addr;
        r_rd_remaining    <= w_total;
        r_beats_remaining <= w_total;
      end else begin
        if (w_issue) begin
          r_addr         <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          r_rd_remaining <= r_rd_remaining - 16'd1;
        end
        if (w_pop) begin
          r_beats_remaining <= r_beats_remaining - 16'd1;
        end
      end
      r_inflight <= w_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO: returned read data is pushed the cycle after issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= buf_rd_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Clear-on-read write port
  // ---------------------------------------------------------------------------
`ifdef DRAIN_CLEAR_ON_READ_EN
  logic              r_clr_en;
  logic [ADDR_W-1:0] r_clr_addr;

  // The buffer is read-first, so clearing one cycle after the read can never
  // corrupt the live beat.
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_clr_en   <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      r_clr_en   <= w_issue;
      r_clr_addr <= r_addr;
    end
  end

  assign buf_wr_en   = r_clr_en;
  assign buf_wr_addr = r_clr_addr;
  assign buf_wr_data = '0;
`else
  assign buf_wr_en   = 1'b0;
  assign buf_wr_addr = '0;
  assign buf_wr_data = '0;
`endif

endmodule

// File: tb/tb_output_buffer_drain.sv
// tb_output_buffer_drain
//   Drives output_buffer_drain against a behavioural buffer and checks every
//   streamed beat against the expected N*N word sequence from base upward.

module tb_output_buffer_drain;

  logic        w_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [7:0]  featuremap_size = 8'd0;
  logic        buf_is_empty = 1'b0;
  logic        buf_rd_en;
  logic [15:0] buf_rd_addr;
  logic [15:0] buf_rd_data;
  logic        buf_wr_en;
  logic [15:0] buf_wr_addr;
  logic [15:0] buf_wr_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 w_clk = ~w_clk;

  output_buffer_drain #(.ADDR_W(16), .DATA_W(16)) dut (
    .w_clk           (w_clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .featuremap_size (featuremap_size),
    .buf_is_empty    (buf_is_empty),
    .buf_rd_en       (buf_rd_en),
    .buf_rd_addr     (buf_rd_addr),
    .buf_rd_data     (buf_rd_data),
    .buf_wr_en       (buf_wr_en),
    .buf_wr_addr     (buf_wr_addr),
    .buf_wr_data     (buf_wr_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy),
    .done            (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Buffer contents: a fixed nonzero word per address.
  function automatic logic [15:0] pattern(input logic [15:0] a);
    return ((a * 16'h9E37) ^ 16'h5A5A) | 16'h8000;
  endfunction

  // Behavioural read-first buffer. A location cleared during the current
  // run's epoch reads back 0; a new epoch restores the original pattern.
  int epoch = 1;
  int clr_epoch [65536];
  initial buf_rd_data = 16'd0;
  always @(posedge w_clk) begin
    if (buf_rd_en)
      buf_rd_data <= (clr_epoch[buf_rd_addr] == epoch) ? 16'd0 : pattern(buf_rd_addr);
    if (buf_wr_en && (buf_wr_data == 16'd0))
      clr_epoch[buf_wr_addr] <= epoch;
  end

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_en"},   buf_rd_en,   0);
    chk({nm, "_rd_addr"}, buf_rd_addr, 0);
    chk({nm, "_wr_en"},   buf_wr_en,   0);
    chk({nm, "_wr_addr"}, buf_wr_addr, 0);
    chk({nm, "_m_valid"}, m_valid,     0);
    chk({nm, "_m_data"},  m_data,      0);
    chk({nm, "_m_last"},  m_last,      0);
    chk({nm, "_busy"},    busy,        0);
    chk({nm, "_done"},    done,        0);
  endtask

  // mode: 0 ready always high, 1 ready 1,0,0 repeating, 2 random ready.
  // rst_after > 0: apply reset (with start) after that many accepted beats.
  task automatic run_drain(input logic [15:0] base, input logic [7:0] n,
                           input int mode, input int rst_after, input string nm);
    int          total, reads, beats, last_acc, done_cyc, first_rd, first_vld, budget;
    logic        prev_stall, prev_rd;
    logic [15:0] prev_data, prev_rd_addr;
    total     = int'(n) * int'(n);
    epoch++;
    budget    = 4 * total + 40;
    reads     = 0;
    beats     = 0;
    last_acc  = -1;
    done_cyc  = -1;
    first_rd  = -1;
    first_vld = -1;
    prev_stall   = 1'b0;
    prev_rd      = 1'b0;
    prev_data    = 16'd0;
    prev_rd_addr = 16'd0;

    @(posedge w_clk); #1;
    start = 1'b1; base_addr = base; featuremap_size = n; buf_is_empty = 1'b0;
    m_ready = ready_for(mode, 0);
    @(negedge w_clk);
    chk({nm, "_c0_busy"},  busy,      0);
    chk({nm, "_c0_rd_en"}, buf_rd_en, 0);

    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(posedge w_clk); #1;
      // A start mid-drain must be ignored; scrambled inputs expose resampling.
      start           = (cyc == 5) && (total >= 4);
      base_addr       = 16'($urandom);
      featuremap_size = 8'($urandom);
      m_ready         = ready_for(mode, cyc);
      @(negedge w_clk);

      if (cyc == 1) chk({nm, "_c1_busy"}, busy, (total != 0) ? 1 : 0);
      if (prev_stall) begin
        chk({nm, "_stall_valid"}, m_valid, 1);
        chk({nm, "_stall_data"},  m_data,  prev_data);
      end
      if (buf_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk({nm, "_rd_addr"}, buf_rd_addr, 32'(16'(base + reads)));
        reads++;
      end
      if (m_valid) chk({nm, "_last"}, m_last, (beats == total - 1) ? 1 : 0);
      if (m_valid && m_ready) begin
        if (first_vld < 0) first_vld = cyc;
        chk({nm, "_data"}, m_data, 32'(pattern(16'(base + beats))));
        if (mode == 0) chk({nm, "_beat_cyc"}, cyc, 3 + beats);
        beats++;
        last_acc = cyc;
      end
      chk({nm, "_occupancy"}, ((reads - beats) <= 2) ? 1 : 0, 1);
`ifdef DRAIN_CLEAR_ON_READ_EN
      chk({nm, "_clr_en"}, buf_wr_en, prev_rd);
      if (prev_rd) begin
        chk({nm, "_clr_addr"}, buf_wr_addr, prev_rd_addr);
        chk({nm, "_clr_data"}, buf_wr_data, 0);
      end
`else
      chk({nm, "_wr_en"}, buf_wr_en, 0);
`endif
      prev_rd      = buf_rd_en;
      prev_rd_addr = buf_rd_addr;
      prev_stall   = m_valid & ~m_ready;
      prev_data    = m_data;
      if (done) begin
        done_cyc = cyc;
        chk({nm, "_done_busy"}, busy, 0);
      end

      if (rst_after > 0 && beats == rst_after) begin
        // Reset and start together: reset must win.
        @(posedge w_clk); #1;
        reset = 1'b1; start = 1'b1; featuremap_size = 8'd4;
        @(posedge w_clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge w_clk);
        chk_all_zero({nm, "_post_rst"});
        for (int k = 0; k < 6; k++) begin
          @(posedge w_clk); #1;
          @(negedge w_clk);
          chk({nm, "_post_rst_done"},  done,      0);
          chk({nm, "_post_rst_rd_en"}, buf_rd_en, 0);
          chk({nm, "_post_rst_valid"}, m_valid,   0);
        end
        return;
      end
    end

    chk({nm, "_reads"}, reads, total);
    chk({nm, "_beats"}, beats, total);
    if (total == 0) begin
      chk({nm, "_done_cyc"}, done_cyc, 1);
      chk({nm, "_first_rd"}, first_rd, 32'hFFFF_FFFF);
    end else begin
      chk({nm, "_done_cyc"}, done_cyc, last_acc + 1);
      chk({nm, "_first_rd"}, first_rd, 1);
      if (mode == 0) begin
        chk({nm, "_first_vld"},    first_vld, 3);
        chk({nm, "_done_cyc_abs"}, done_cyc,  total + 3);
      end
    end
    @(posedge w_clk); #1;
    start = 1'b0; m_ready = 1'b1;
    @(negedge w_clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_idle_busy"},  busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    chk_all_zero("reset");
    @(posedge w_clk); #1;
    reset = 1'b0;

    run_drain(16'h0010, 8'd4, 0, 0, "n4");
    run_drain(16'h0100, 8'd3, 1, 0, "n3_toggle");
    run_drain(16'hFFFE, 8'd2, 0, 0, "wrap");
    run_drain(16'h0500, 8'd0, 0, 0, "n0");

    // start while the buffer is empty is ignored
    @(posedge w_clk); #1;
    start = 1'b1; buf_is_empty = 1'b1; featuremap_size = 8'd4; base_addr = 16'h0700;
    @(posedge w_clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge w_clk);
      chk("empty_busy",  busy,      0);
      chk("empty_rd_en", buf_rd_en, 0);
      chk("empty_done",  done,      0);
      @(posedge w_clk); #1;
    end
    buf_is_empty = 1'b0;

    run_drain(16'h0800, 8'd8, 0, 5, "mid_rst");
    run_drain(16'h0900, 8'd1, 0, 0, "n1");
    run_drain(16'h0020, 8'd2, 0, 0, "clr");

    for (int r = 0; r < 6; r++)
      run_drain(16'($urandom), 8'($urandom_range(1, 12)), 2, 0, "rand");

    run_drain(16'h3000, 8'd255, 0, 0, "n255");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_buffer_drain.md
Name: output_buffer_drain

Overview:
Reads a completed output feature map out of the on-chip output buffer and streams it to the next layer or writeback path over a valid/ready interface. The buffer's fill controller writes the feature map; this block drains it. It runs from a base address for size*size entries. Buffer reads have a fixed 1-cycle latency, and a 2-entry skid FIFO absorbs downstream backpressure without losing read data.

Parameters:
ADDR_W, 16, buffer address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, buffer word / stream data width

Ports:
w_clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a drain; ignored unless state is IDLE
base_addr  in  ADDR_W  first buffer address, sampled when start is accepted
featuremap_size  in  8  side length N; entries drained = N*N (16-bit product), sampled with start
buf_is_empty  in  1  buffer holds no valid map; start is ignored while high
buf_rd_en  out  1  buffer read strobe
buf_rd_addr  out  ADDR_W  buffer read address
buf_rd_data  in  DATA_W  read data, valid the cycle after buf_rd_en
buf_wr_en  out  1  clear-on-read write strobe (see Optional Feature)
buf_wr_addr  out  ADDR_W  clear-on-read address
buf_wr_data  out  DATA_W  clear-on-read data, always 0
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_W  stream data
m_last  out  1  high with the final beat
busy  out  1  drain in progress
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: state IDLE. buf_rd_en, buf_wr_en, m_valid, m_last, busy and done are 0. buf_rd_addr, buf_wr_addr and m_data are 0. FIFO and in-flight tracking are cleared.
- Reset mid-drain: takes effect at the next edge. In-flight read data is discarded and no done pulse is produced.
- FSM states IDLE, DRAIN, FLUSH, DONE.
- IDLE -> DRAIN: start=1 and buf_is_empty=0 in cycle 0.
  - Latch base_addr and total = N*N.
  - Set rd_remaining = total and beats_remaining = total.
  - busy=1 from cycle 1.
- IDLE -> DONE: start=1 with total=0. No reads are issued; done pulses in cycle 1.
- Read issue in DRAIN: buf_rd_en=1 when rd_remaining>0 and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready. buf_rd_en may be combinational from registered state and m_ready.
- Each issued read decrements rd_remaining and increments the address by 1, wrapping modulo 2^ADDR_W.
- Returned data is pushed into the FIFO the cycle after issue. m_valid is asserted the cycle after the push.
- Latency and throughput: start in cycle 0 -> first buf_rd_en in cycle 1 -> first m_valid in cycle 3. With m_ready held high, throughput is 1 beat per cycle.
- FIFO rules: never overflows and never drops data. m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- DRAIN -> FLUSH: when rd_remaining reaches 0.
- FLUSH -> DONE: the cycle the beat with beats_remaining==1 is accepted. m_last=1 exactly on that beat.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE.
- start asserted while not IDLE is ignored. Simultaneous start and reset: reset wins.
- total=1: exactly one read and one beat, with m_last=1 on that beat.
- total=65025 (N=255): the counter must not overflow.

Optional Feature:
Macro DRAIN_CLEAR_ON_READ_EN.
- Defined: every buf_rd_en also drives buf_wr_en=1 one cycle later, with buf_wr_addr = that read address and buf_wr_data=0. This zeroes the buffer for the next accumulation pass. The buffer is read-first, so a read followed by a clear never returns 0 for the live beat.
- Not defined: buf_wr_en, buf_wr_addr and buf_wr_data are tied to 0 and no write logic is built.

Test Plan:
- N=4, base=0x0010, m_ready=1 -> 16 beats on consecutive cycles 3..18 carrying mem[0x10..0x1F]; m_last on beat 16; done in cycle 19.
- N=3, m_ready toggling 1,0,0,1,... -> 9 beats in order; m_data stable during stalls; never more than 2 outstanding reads plus FIFO entries; no beat lost or duplicated.
- N=2, base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; 4 beats; m_last on the 4th.
- N=0 start -> no buf_rd_en; done in cycle 1. Separately, start with buf_is_empty=1 -> ignored, busy stays 0.
- N=8, reset asserted after beat 5 -> all outputs 0 next cycle and no done. A new start with N=1 then gives 1 beat with m_last=1.
- With DRAIN_CLEAR_ON_READ_EN, N=2, base=0x20 -> buf_wr_en pulses at 0x20..0x23 with data 0, each one cycle after its read; the streamed data is the original contents.
